// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM control unit for the multicycle MIPS datapath
// Sequences fetch/decode/execute/memory/writeback with optional memory wait states and bne.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter bit MEM_WAIT   = 1'b1,
  parameter bit EN_BNE     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            OPcode,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  input  logic                  mem_ready,
  output logic                  IorD,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  PCEn,
  output logic                  RegDst,
  output logic                  MemtoReg,
  output logic                  RegWrite,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            PCSrc,
  output logic [ALU_CTRL_W-1:0] ALU_control,
  output logic                  illegal_op,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
    BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
  } state_t;

  typedef struct packed {
    logic                  iord;
    logic                  mem_write;
    logic                  ir_write;
    logic                  pc_write;
    logic                  branch;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_control;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

  function automatic logic [ALU_CTRL_W-1:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // Datapath controls for a given state; mem_ready/Zero gating is applied on the outputs.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; c.alu_control = ALU_ADD; end
      DECODE:  begin c.alu_src_b = 2'b11; c.alu_control = ALU_ADD; end
      MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      EXECUTE: begin c.alu_src_a = 1'b1; c.alu_control = funct_alu(f); end
      ALUWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BRANCH:  begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_src = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = ALU_ADD; end
      ADDIWB:  c.reg_write = 1'b1;
      JUMP:    begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t cur, nxt;
  ctrl_t  ctrl;
  logic   ready, bad_opcode, fetch_ok, is_bne;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  always_comb begin
    nxt        = FETCH;
    bad_opcode = 1'b0;
    case (cur)
      FETCH:   nxt = ready ? DECODE : FETCH;
      DECODE: begin
        case (OPcode)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
          OP_BNE: begin
            nxt        = EN_BNE ? BRANCH : FETCH;
            bad_opcode = !EN_BNE;
          end
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      bad_opcode = 1'b1;
        endcase
      end
      MEMADR:  nxt = (OPcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = ready ? MEMWB : MEMRD;
      MEMWR:   nxt = ready ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= FETCH;
      ctrl <= decode(FETCH, 6'b000000);
    end else begin
      cur  <= nxt;
      ctrl <= decode(nxt, Funct);
    end
  end

  assign fetch_ok = (cur != FETCH) || ready;
  assign is_bne   = (OPcode == OP_BNE);

  assign IorD        = ctrl.iord;
  assign MemWrite    = !rst && ctrl.mem_write;
  assign IRWrite     = !rst && ctrl.ir_write && fetch_ok;
  assign PCEn        = !rst && ((ctrl.pc_write && fetch_ok) || (ctrl.branch && (is_bne ? !Zero : Zero)));
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = !rst && ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSrc       = ctrl.pc_src;
  assign ALU_control = ctrl.alu_control;
  assign illegal_op  = !rst && (cur == DECODE) && bad_opcode;
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
// dut uses default parameters; dut2 uses MEM_WAIT=0, EN_BNE=0 and shares the inputs.
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OPcode, Funct;
  logic       Zero, mem_ready;

  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_control;
  logic [3:0] state;

  logic       IorD2, MemWrite2, IRWrite2, PCEn2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2, illegal_op2;
  logic [1:0] ALUSrcB2, PCSrc2;
  logic [2:0] ALU_control2;
  logic [3:0] state2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .ALU_control(ALU_control), .illegal_op(illegal_op), .state(state)
  );

  multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_WAIT(1'b0), .EN_BNE(1'b0)) dut2 (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD2), .MemWrite(MemWrite2), .IRWrite(IRWrite2), .PCEn(PCEn2), .RegDst(RegDst2),
    .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
    .PCSrc(PCSrc2), .ALU_control(ALU_control2), .illegal_op(illegal_op2), .state(state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b1; OPcode = 6'b101011; Funct = 6'b0; Zero = 1'b0;
    tick();
    total_cnt++;
    if ({state, IRWrite, PCEn, MemWrite, RegWrite, illegal_op} !== 9'b0000_00000)
      $display("FAIL reset_hold: got state=%0d en=%b expected state=0 en=00000",
               state, {IRWrite, PCEn, MemWrite, RegWrite, illegal_op});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({IRWrite, PCEn, ALUSrcB, ALU_control} !== {1'b1, 1'b1, 2'b01, 3'b010})
      $display("FAIL fetch_outputs: got %b expected 1101010", {IRWrite, PCEn, ALUSrcB, ALU_control});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (state !== 4'd1) $display("FAIL fetch_to_decode: got %0d expected 1", state);
    else pass_cnt++;
    tick();
    mem_ready = 1'b0;
    tick();
    total_cnt++;
    if ({state, MemWrite} !== {4'd5, 1'b1}) $display("FAIL memwr_enter: got state=%0d MemWrite=%b expected 5 1", state, MemWrite);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({state, MemWrite} !== 5'b0) $display("FAIL async_reset: got state=%0d MemWrite=%b expected 0 0", state, MemWrite);
    else pass_cnt++;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_lw_waits();
    logic [3:0] exp_state [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       ready_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    OPcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = ready_pat[i];
      #1;
      total_cnt++;
      if (state !== exp_state[i]) $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_state[i]);
      else pass_cnt++;
      total_cnt++;
      if ({RegWrite, MemtoReg} !== ((exp_state[i] == 4'd4) ? 2'b11 : 2'b00))
        $display("FAIL lw_writeback[%0d]: got %b expected %b", i, {RegWrite, MemtoReg},
                 (exp_state[i] == 4'd4) ? 2'b11 : 2'b00);
      else pass_cnt++;
      if (i < 7) tick();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] functs [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100000, 6'b111000};
    logic [2:0] codes  [6] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b010};
    mem_ready = 1'b1; OPcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      Funct = functs[i];
      tick(); tick();
      total_cnt++;
      if ({state, ALU_control} !== {4'd6, codes[i]})
        $display("FAIL rtype_exec[%0d]: got state=%0d alu=%b expected 6 %b", i, state, ALU_control, codes[i]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({state, RegDst, RegWrite} !== {4'd7, 2'b11})
        $display("FAIL rtype_wb[%0d]: got state=%0d RegDst/RegWrite=%b expected 7 11", i, state, {RegDst, RegWrite});
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_branches();
    logic [5:0] ops  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       zs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       pcen [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      OPcode = ops[i]; Zero = zs[i];
      tick(); tick();
      total_cnt++;
      if ({state, PCEn, PCSrc, ALU_control} !== {4'd8, pcen[i], 2'b01, 3'b110})
        $display("FAIL branch[%0d]: got state=%0d PCEn=%b PCSrc=%b alu=%b expected 8 %b 01 110",
                 i, state, PCEn, PCSrc, ALU_control, pcen[i]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 4'd0) $display("FAIL branch_return[%0d]: got %0d expected 0", i, state);
      else pass_cnt++;
    end
    Zero = 1'b0;
  endtask

  task automatic test_jump_illegal();
    mem_ready = 1'b1; OPcode = 6'b000010;
    tick(); tick();
    total_cnt++;
    if ({state, PCSrc, PCEn} !== {4'd11, 2'b10, 1'b1})
      $display("FAIL jump: got state=%0d PCSrc=%b PCEn=%b expected 11 10 1", state, PCSrc, PCEn);
    else pass_cnt++;
    tick();
    OPcode = 6'b111111;
    tick();
    total_cnt++;
    if ({state, illegal_op, MemWrite, IRWrite, PCEn, RegWrite} !== {4'd1, 1'b1, 4'b0000})
      $display("FAIL illegal_decode: got state=%0d ill=%b en=%b expected 1 1 0000",
               state, illegal_op, {MemWrite, IRWrite, PCEn, RegWrite});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state, illegal_op} !== 5'b0) $display("FAIL illegal_return: got state=%0d ill=%b expected 0 0", state, illegal_op);
    else pass_cnt++;
  endtask

  task automatic test_addi();
    logic [3:0] exp_state [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    mem_ready = 1'b1; OPcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (state !== exp_state[i]) $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, exp_state[i]);
      else pass_cnt++;
      if (i == 3) begin
        total_cnt++;
        if ({RegWrite, RegDst, MemtoReg} !== 3'b100) $display("FAIL addi_wb: got %b expected 100", {RegWrite, RegDst, MemtoReg});
        else pass_cnt++;
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_nowait_sw();
    logic [3:0] exp_state [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    int writes = 0;
    do_reset();
    mem_ready = 1'b0; OPcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if (state2 !== exp_state[i]) $display("FAIL sw_nowait_state[%0d]: got %0d expected %0d", i, state2, exp_state[i]);
      else pass_cnt++;
      if (MemWrite2) writes++;
      if (exp_state[i] == 4'd5) begin
        total_cnt++;
        if (IorD2 !== 1'b1) $display("FAIL sw_nowait_iord: got %b expected 1", IorD2);
        else pass_cnt++;
      end
      if (i < 4) tick();
    end
    total_cnt++;
    if (writes != 1) $display("FAIL sw_nowait_writes: got %0d expected 1", writes);
    else pass_cnt++;
  endtask

  task automatic test_bne_disabled();
    do_reset();
    mem_ready = 1'b1; OPcode = 6'b000101; Zero = 1'b0;
    tick();
    total_cnt++;
    if ({state2, illegal_op2} !== {4'd1, 1'b1}) $display("FAIL bne_disabled: got state=%0d ill=%b expected 1 1", state2, illegal_op2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({state2, illegal_op2, PCEn2} !== {4'd0, 1'b0, 1'b1})
      $display("FAIL bne_disabled_return: got state=%0d ill=%b PCEn=%b expected 0 0 1", state2, illegal_op2, PCEn2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw_waits();
    test_rtype();
    test_branches();
    test_jump_illegal();
    test_addi();
    test_nowait_sw();
    test_bne_disabled();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish before 50000");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle control unit, for the multicycle MIPS datapath with one shared instruction/data memory.
- A Moore FSM sequences fetch, decode, execute, memory and writeback steps, one per clock.
- Adds optional memory wait-state handshaking, optional bne support and an illegal-opcode flag.
- Sits between the instruction register (OPcode/Funct) and the datapath multiplexers and enables.

Parameters:
- ALU_CTRL_W, 3: width of ALU_control. Codes are zero-extended into this width.
- MEM_WAIT, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- EN_BNE, 1: 1 = opcode 000101 (bne) is decoded; 0 = it is treated as illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- OPcode  in  6  Instr[31:26] from the instruction register
- Funct  in  6  Instr[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- PCEn  out  1  PC load (PCWrite | (Branch & branch condition))
- RegDst  out  1  destination register select: 1 = rd, 0 = rt
- MemtoReg  out  1  writeback data select: 1 = Data register, 0 = ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALU_control  out  ALU_CTRL_W  ALU operation
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- state  out  4  current FSM state, for debug

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state is FETCH. While rst is high, every enable output (MemWrite, IRWrite, PCEn, RegWrite) and illegal_op are 0. All other outputs take their FETCH values.
- All outputs are decoded from state only, except:
  - PCEn, which also depends on Zero.
  - The write enables gated by mem_ready, listed below.
  Unlisted outputs are 0; ALUSrcB and PCSrc are 00.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
  - In EXECUTE, Funct decodes as: 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other Funct → add, with RegWrite still asserted in ALUWB.
- States, with outputs and next state:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00. IRWrite and PCEn are asserted only when mem_ready=1. If mem_ready=0, stay in FETCH; if 1, go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq, or bne when EN_BNE=1 → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - anything else → FETCH, with illegal_op=1 for this cycle
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, add. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
  - MEMWR(5): IorD=1, MemWrite=1 held for every wait cycle. Go to FETCH on mem_ready.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, Funct-decoded code. Next is ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. PCEn = Zero for beq, ~Zero for bne. Next is FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, add. Next is ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
  - JUMP(11): PCSrc=10, PCEn=1. Next is FETCH.
  - Encodings 12–15 are unreachable; they go to FETCH with no enables asserted.
- Latency without waits, in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- OPcode and Funct are sampled continuously. The instruction register is stable after FETCH, so the FSM does not latch them.
- Reset asserted mid-instruction returns to FETCH immediately (asynchronously). No partial register or memory write occurs after the reset edge.

Test Plan:
- Reset and fetch: assert rst mid-MEMWR → state=0 and MemWrite=0 immediately. Release rst with mem_ready=1 → FETCH shows IRWrite=1, PCEn=1, ALUSrcB=01, ALU_control=010; DECODE follows next cycle.
- lw with waits: OPcode=100011, mem_ready low for 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; 7 cycles total.
- R-type: OPcode=0 with Funct 100010 → EXECUTE gives ALU_control=110; ALUWB gives RegDst=1, RegWrite=1. Repeat for the and, or and slt Funct codes: 000, 001, 111.
- Branches: beq with Zero=1 → PCEn=1, PCSrc=01 in BRANCH. beq with Zero=0 → PCEn=0. bne with Zero=0 → PCEn=1. bne with EN_BNE=0 → illegal_op pulse, then FETCH.
- sw with MEM_WAIT=0: mem_ready held 0 → sequence 0,1,2,5,0. MemWrite=1 for exactly one cycle, IorD=1.
- Jump and illegal: OPcode=000010 → JUMP with PCSrc=10, PCEn=1, then FETCH. OPcode=111111 → one illegal_op pulse in DECODE, no enables, then FETCH.
